// File: rtl/alu_seq_pkg.sv
// ==== alu_seq_pkg: states, instruction classes and mux/ALU encodings for alu_seq_ctrl ====
// ==== rev 1.0 | optional addm support via ALU_SEQ_ADDM_EN ====
`default_nettype none

package alu_seq_pkg;

   typedef enum logic [3:0] {
      S_START,
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_WB_R,
      S_EXEC_I,
      S_WB_I,
      S_ADDR,
      S_MEM_RD,
      S_WB_LW,
      S_MEM_WR,
      S_BRANCH,
      S_JUMP,
      S_TRAP
`ifdef ALU_SEQ_ADDM_EN
      , S_ADDM_RD
      , S_ADDM_EX
`endif
   } state_t;

   typedef enum logic [2:0] {
      CLS_R_ALU,
      CLS_ADDI,
      CLS_LOAD,
      CLS_STORE,
      CLS_BRANCH,
      CLS_JUMP,
      CLS_ADDM,
      CLS_ILLEGAL
   } instr_class_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_J     = 6'h02;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_ADDM  = 6'h05;

   localparam logic [1:0] ALU_SRC_A_PC   = 2'b00;
   localparam logic [1:0] ALU_SRC_A_REGA = 2'b01;
   localparam logic [1:0] ALU_SRC_A_REGB = 2'b10;

   localparam logic [2:0] ALU_SRC_B_REGB     = 3'b000;
   localparam logic [2:0] ALU_SRC_B_MDR      = 3'b001;
   localparam logic [2:0] ALU_SRC_B_SEXT     = 3'b010;
   localparam logic [2:0] ALU_SRC_B_FOUR     = 3'b011;
   localparam logic [2:0] ALU_SRC_B_SEXT_SH2 = 3'b100;

   localparam logic [2:0] ALU_OP_AND = 3'b000;
   localparam logic [2:0] ALU_OP_OR  = 3'b001;
   localparam logic [2:0] ALU_OP_ADD = 3'b010;
   localparam logic [2:0] ALU_OP_SUB = 3'b110;
   localparam logic [2:0] ALU_OP_SLT = 3'b111;

   localparam logic [1:0] PC_SRC_ALU    = 2'b00;
   localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

   localparam logic [1:0] IORD_PC     = 2'b00;
   localparam logic [1:0] IORD_ALUOUT = 2'b01;
   localparam logic [1:0] IORD_REGA   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/alu_seq_decode.sv
// ==== alu_seq_decode: combinational opcode/funct -> instruction class and R-type ALU op ====
// ==== rev 1.0 | CLS_ADDM only produced when ALU_SEQ_ADDM_EN is defined ====
`default_nettype none

module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [5:0]   opcode,
   input  logic [5:0]   funct,
   output instr_class_t instr_class,
   output logic [2:0]   funct_op
);

   always_comb begin
      instr_class = CLS_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: instr_class = CLS_R_ALU;
`ifdef ALU_SEQ_ADDM_EN
               FN_ADDM: instr_class = CLS_ADDM;
`endif
               default: instr_class = CLS_ILLEGAL;
            endcase
         end
         OP_ADDI:        instr_class = CLS_ADDI;
         OP_LW:          instr_class = CLS_LOAD;
         OP_SW:          instr_class = CLS_STORE;
         OP_BEQ, OP_BNE: instr_class = CLS_BRANCH;
         OP_J:           instr_class = CLS_JUMP;
         default:        instr_class = CLS_ILLEGAL;
      endcase
   end

   always_comb begin
      funct_op = ALU_OP_ADD;
      case (funct)
         FN_SUB:  funct_op = ALU_OP_SUB;
         FN_AND:  funct_op = ALU_OP_AND;
         FN_OR:   funct_op = ALU_OP_OR;
         FN_SLT:  funct_op = ALU_OP_SLT;
         default: funct_op = ALU_OP_ADD;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/alu_seq_ctrl.sv
// ==== alu_seq_ctrl: multicycle control sequencer driving ALU muxes, ALU op and write strobes ====
// ==== rev 1.0 | ALU_SEQ_ADDM_EN adds the addm (rd = mem[rs] + rt) sequence ====
`default_nettype none

module alu_seq_ctrl
   import alu_seq_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       alu_zero,
   input  logic       mem_ready,
   output logic [1:0] alu_src_a,
   output logic [2:0] alu_src_b,
   output logic [2:0] alu_op,
   output logic       alu_out_we,
   output logic       pc_we,
   output logic       ir_we,
   output logic       mdr_we,
   output logic       reg_we,
   output logic       mem_req,
   output logic       mem_we,
   output logic [1:0] pc_src,
   output logic [1:0] iord,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       illegal_op
);

   state_t       state;
   state_t       state_nxt;
   instr_class_t instr_class;
   logic [2:0]   funct_op;
   logic         is_bne;
   logic         is_store;

   alu_seq_decode u_decode (
      .opcode      (opcode),
      .funct       (funct),
      .instr_class (instr_class),
      .funct_op    (funct_op)
   );

   // Branch flavour and load/store direction are captured in DECODE so later
   // states do not depend on the IR.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_START;
         is_bne   <= 1'b0;
         is_store <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == S_DECODE) begin
            is_bne   <= (opcode == OP_BNE);
            is_store <= (opcode == OP_SW);
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      alu_src_a  = ALU_SRC_A_PC;
      alu_src_b  = ALU_SRC_B_REGB;
      alu_op     = ALU_OP_AND;
      alu_out_we = 1'b0;
      pc_we      = 1'b0;
      ir_we      = 1'b0;
      mdr_we     = 1'b0;
      reg_we     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_src     = PC_SRC_ALU;
      iord       = IORD_PC;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal_op = 1'b0;

      case (state)
         S_START: state_nxt = S_FETCH;
         S_FETCH: begin
            mem_req   = 1'b1;
            iord      = IORD_PC;
            alu_src_a = ALU_SRC_A_PC;
            alu_src_b = ALU_SRC_B_FOUR;
            alu_op    = ALU_OP_ADD;
            if (mem_ready) begin
               ir_we     = 1'b1;
               pc_we     = 1'b1;
               pc_src    = PC_SRC_ALU;
               state_nxt = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a  = ALU_SRC_A_PC;
            alu_src_b  = ALU_SRC_B_SEXT_SH2;
            alu_op     = ALU_OP_ADD;
            alu_out_we = 1'b1;
            case (instr_class)
               CLS_R_ALU:            state_nxt = S_EXEC_R;
               CLS_ADDI:             state_nxt = S_EXEC_I;
               CLS_LOAD, CLS_STORE:  state_nxt = S_ADDR;
               CLS_BRANCH:           state_nxt = S_BRANCH;
               CLS_JUMP:             state_nxt = S_JUMP;
`ifdef ALU_SEQ_ADDM_EN
               CLS_ADDM:             state_nxt = S_ADDM_RD;
`endif
               default:              state_nxt = S_TRAP;
            endcase
         end
         S_EXEC_R: begin
            alu_src_a  = ALU_SRC_A_REGA;
            alu_src_b  = ALU_SRC_B_REGB;
            alu_op     = funct_op;
            alu_out_we = 1'b1;
            state_nxt  = S_WB_R;
         end
         S_WB_R: begin
            reg_we    = 1'b1;
            reg_dst   = 1'b1;
            state_nxt = S_FETCH;
         end
         S_EXEC_I, S_ADDR: begin
            alu_src_a  = ALU_SRC_A_REGA;
            alu_src_b  = ALU_SRC_B_SEXT;
            alu_op     = ALU_OP_ADD;
            alu_out_we = 1'b1;
            if (state == S_EXEC_I) state_nxt = S_WB_I;
            else                   state_nxt = is_store ? S_MEM_WR : S_MEM_RD;
         end
         S_WB_I: begin
            reg_we    = 1'b1;
            state_nxt = S_FETCH;
         end
         S_MEM_RD: begin
            mem_req = 1'b1;
            iord    = IORD_ALUOUT;
            if (mem_ready) begin
               mdr_we    = 1'b1;
               state_nxt = S_WB_LW;
            end
         end
         S_WB_LW: begin
            reg_we     = 1'b1;
            mem_to_reg = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEM_WR: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            iord    = IORD_ALUOUT;
            if (mem_ready) state_nxt = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a = ALU_SRC_A_REGA;
            alu_src_b = ALU_SRC_B_REGB;
            alu_op    = ALU_OP_SUB;
            pc_src    = PC_SRC_ALUOUT;
            pc_we     = is_bne ? ~alu_zero : alu_zero;
            state_nxt = S_FETCH;
         end
         S_JUMP: begin
            pc_we     = 1'b1;
            pc_src    = PC_SRC_JUMP;
            state_nxt = S_FETCH;
         end
         S_TRAP: illegal_op = 1'b1;
`ifdef ALU_SEQ_ADDM_EN
         S_ADDM_RD: begin
            mem_req = 1'b1;
            iord    = IORD_REGA;
            if (mem_ready) begin
               mdr_we    = 1'b1;
               state_nxt = S_ADDM_EX;
            end
         end
         S_ADDM_EX: begin
            alu_src_a  = ALU_SRC_A_REGB;
            alu_src_b  = ALU_SRC_B_MDR;
            alu_op     = ALU_OP_ADD;
            alu_out_we = 1'b1;
            state_nxt  = S_WB_R;
         end
`endif
         default: state_nxt = S_START;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_seq_ctrl.sv
// ==== tb_alu_seq_ctrl: per-instruction expected-output model checked cycle by cycle ====
// ==== rev 1.0 | honours ALU_SEQ_ADDM_EN the same way as the design ====
`default_nettype none

module tb_alu_seq_ctrl;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [5:0] opcode = 6'h00;
   logic [5:0] funct = 6'h00;
   logic       alu_zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic [1:0] alu_src_a;
   logic [2:0] alu_src_b;
   logic [2:0] alu_op;
   logic       alu_out_we, pc_we, ir_we, mdr_we, reg_we, mem_req, mem_we;
   logic [1:0] pc_src, iord;
   logic       reg_dst, mem_to_reg, illegal_op;

   alu_seq_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .funct      (funct),
      .alu_zero   (alu_zero),
      .mem_ready  (mem_ready),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .alu_out_we (alu_out_we),
      .pc_we      (pc_we),
      .ir_we      (ir_we),
      .mdr_we     (mdr_we),
      .reg_we     (reg_we),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .pc_src     (pc_src),
      .iord       (iord),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .illegal_op (illegal_op)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0] a;
      logic [2:0] b;
      logic [2:0] op;
      logic       aowe, pcwe, irwe, mdrwe, regwe, mreq, mwe;
      logic [1:0] pcsrc, iord;
      logic       rdst, m2r, ill;
   } outs_t;

   outs_t got;
   assign got = {alu_src_a, alu_src_b, alu_op, alu_out_we, pc_we, ir_we, mdr_we,
                 reg_we, mem_req, mem_we, pc_src, iord, reg_dst, mem_to_reg, illegal_op};

   int tests = 0;
   int fails = 0;

   bit    rdy_q[$];
   bit    z_q[$];
   outs_t exp_q[$];
   string tag_q[$];

   logic [5:0] legal_op [0:10] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02};
   logic [5:0] legal_fn [0:10] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h11, 6'h3F, 6'h00, 6'h20, 6'h05, 6'h2A};

   function automatic bit rb();
      return bit'($urandom_range(0, 1));
   endfunction

   function automatic logic [2:0] alu_code(input logic [5:0] fn);
      case (fn)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         default: return 3'b111;
      endcase
   endfunction

   task automatic check(input outs_t exp, input string tag);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic push(input bit rdy, input bit z, input outs_t x, input string tag);
      rdy_q.push_back(rdy);
      z_q.push_back(z);
      exp_q.push_back(x);
      tag_q.push_back(tag);
   endtask

   // A memory phase: 'waits' stalled request cycles, then the accepting cycle.
   task automatic mem_phase(input int waits, input outs_t stall, input outs_t done, input string tag);
      for (int i = 0; i < waits; i++) push(1'b0, rb(), stall, tag);
      push(1'b1, rb(), done, tag);
   endtask

   // Expected per-cycle outputs for one instruction, from its architectural meaning.
   task automatic model(input logic [5:0] op, input logic [5:0] fn,
                        input int wf, input int wm, input bit z);
      outs_t x, y;
      opcode = op;
      funct  = fn;
      x = '0; x.mreq = 1'b1; x.b = 3'b011; x.op = 3'b010;
      y = x;  y.irwe = 1'b1; y.pcwe = 1'b1;
      mem_phase(wf, x, y, "fetch");
      x = '0; x.b = 3'b100; x.op = 3'b010; x.aowe = 1'b1;
      push(rb(), rb(), x, "decode");
      if (op == 6'h00 && fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
         x = '0; x.a = 2'b01; x.op = alu_code(fn); x.aowe = 1'b1;
         push(rb(), rb(), x, "exec_r");
         x = '0; x.regwe = 1'b1; x.rdst = 1'b1;
         push(rb(), rb(), x, "wb_r");
`ifdef ALU_SEQ_ADDM_EN
      end else if (op == 6'h00 && fn == 6'h05) begin
         x = '0; x.mreq = 1'b1; x.iord = 2'b10;
         y = x;  y.mdrwe = 1'b1;
         mem_phase(wm, x, y, "addm_rd");
         x = '0; x.a = 2'b10; x.b = 3'b001; x.op = 3'b010; x.aowe = 1'b1;
         push(rb(), rb(), x, "addm_ex");
         x = '0; x.regwe = 1'b1; x.rdst = 1'b1;
         push(rb(), rb(), x, "addm_wb");
`endif
      end else if (op == 6'h08) begin
         x = '0; x.a = 2'b01; x.b = 3'b010; x.op = 3'b010; x.aowe = 1'b1;
         push(rb(), rb(), x, "exec_i");
         x = '0; x.regwe = 1'b1;
         push(rb(), rb(), x, "wb_i");
      end else if (op == 6'h23 || op == 6'h2B) begin
         x = '0; x.a = 2'b01; x.b = 3'b010; x.op = 3'b010; x.aowe = 1'b1;
         push(rb(), rb(), x, "addr");
         if (op == 6'h23) begin
            x = '0; x.mreq = 1'b1; x.iord = 2'b01;
            y = x;  y.mdrwe = 1'b1;
            mem_phase(wm, x, y, "mem_rd");
            x = '0; x.regwe = 1'b1; x.m2r = 1'b1;
            push(rb(), rb(), x, "wb_lw");
         end else begin
            x = '0; x.mreq = 1'b1; x.mwe = 1'b1; x.iord = 2'b01;
            mem_phase(wm, x, x, "mem_wr");
         end
      end else if (op == 6'h04 || op == 6'h05) begin
         x = '0; x.a = 2'b01; x.op = 3'b110; x.pcsrc = 2'b01;
         x.pcwe = (op == 6'h04) ? z : ~z;
         push(rb(), z, x, "branch");
      end else if (op == 6'h02) begin
         x = '0; x.pcwe = 1'b1; x.pcsrc = 2'b10;
         push(rb(), rb(), x, "jump");
      end else begin
         x = '0; x.ill = 1'b1;
         for (int i = 0; i < 4; i++) push(rb(), rb(), x, "trap");
      end
   endtask

   // Applies queued steps; n < 0 drains the queue.
   task automatic run_q(input int n);
      int done = 0;
      while (exp_q.size() > 0 && (n < 0 || done < n)) begin
         @(negedge clk);
         mem_ready = rdy_q.pop_front();
         alu_zero  = z_q.pop_front();
         #1;
         check(exp_q.pop_front(), tag_q.pop_front());
         done++;
      end
      rdy_q.delete(); z_q.delete(); exp_q.delete(); tag_q.delete();
   endtask

   task automatic do_reset(input string tag);
      outs_t zero = '0;
      reset     = 1'b0;
      mem_ready = 1'b0;
      #1;
      check(zero, tag);
      @(negedge clk);
      check(zero, "reset_held");
      reset = 1'b1;
      #1;
      check(zero, "start");
   endtask

   initial begin
      do_reset("reset_init");

      model(6'h00, 6'h20, 0, 0, 1'b0); run_q(-1);
      model(6'h23, 6'h00, 0, 3, 1'b0); run_q(-1);
      model(6'h04, 6'h00, 0, 0, 1'b1); run_q(-1);
      model(6'h05, 6'h00, 0, 0, 1'b1); run_q(-1);
      model(6'h2B, 6'h00, 2, 1, 1'b0); run_q(-1);

      for (int k = 0; k < 40; k++) begin
         int idx = $urandom_range(0, 10);
         model(legal_op[idx], legal_fn[idx], $urandom_range(0, 3), $urandom_range(0, 3), rb());
         run_q(-1);
      end

      model(6'h3F, 6'h00, 1, 0, 1'b0); run_q(-1);
      do_reset("reset_from_trap");
      model(6'h00, 6'h21, 0, 0, 1'b0); run_q(-1);
      do_reset("reset_from_trap2");
      model(6'h00, 6'h05, 0, 2, 1'b0); run_q(-1);
      do_reset("reset_after_addm");

      // sw with a long stall: stop partway through MEM_WR and reset mid-cycle.
      model(6'h2B, 6'h00, 0, 6, 1'b0);
      run_q(5);
      #2;
      do_reset("reset_mid_memwr");
      model(6'h08, 6'h00, 0, 0, 1'b0); run_q(-1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
